// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32IM decode constants, ALU opcode table and control bundle type.
// No ports; imported by the decoder and the ID/EX stage.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Integer funct3 (OP / OP-IMM)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension funct3
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_XOR    = 5'b00001,
    ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011,
    ALU_MUL    = 5'b00100,
    ALU_MULH   = 5'b00101,
    ALU_MULHU  = 5'b00110,
    ALU_MULHSU = 5'b00111,
    ALU_DIV    = 5'b01000,
    ALU_DIVU   = 5'b01001,
    ALU_REM    = 5'b01010,
    ALU_REMU   = 5'b01011,
    ALU_SLL    = 5'b01101,
    ALU_SRA    = 5'b01110,
    ALU_SLT    = 5'b01111,
    ALU_SUB    = 5'b10000,
    ALU_SLTU   = 5'b10001,
    ALU_SRL    = 5'b10010,
    ALU_PASSB  = 5'b10011
  } alu_op_e;

  typedef enum logic {
    ST_RUN,
    ST_MDU_WAIT
  } state_e;

  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic       mux1_sel;
    logic       mux2_sel;
    logic       mux3_sel;
    logic       jal_sel;
    logic [2:0] imm_sel;
    logic       regwrite_en;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Handshake/bus bundle between the IF/ID side, the decode stage and EX.
// master: drives instruction, PC, stall and flush; observes the ID/EX bundle.
// slave : the decode stage (decode_ctrl_pipe).
interface decode_ctrl_pipe_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
);
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic [XLEN-1:0]  pc_in;
  logic             stall_in;
  logic             flush_in;

  logic             valid_out;
  logic [ALUOP_W-1:0] alu_op;
  logic             mux1_sel;
  logic             mux2_sel;
  logic             mux3_sel;
  logic             jal_sel;
  logic [2:0]       imm_sel;
  logic             regwrite_en;
  logic             mem_read;
  logic             mem_write;
  logic             branch;
  logic             jump;
  logic [2:0]       funct3_out;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [XLEN-1:0]  pc_out;
  logic             illegal_instr;
  logic             stall_out;

  modport master (
    output instr_in, instr_valid, pc_in, stall_in, flush_in,
    input  valid_out, alu_op, mux1_sel, mux2_sel, mux3_sel, jal_sel, imm_sel,
           regwrite_en, mem_read, mem_write, branch, jump, funct3_out,
           rd, rs1, rs2, pc_out, illegal_instr, stall_out
  );

  modport slave (
    input  instr_in, instr_valid, pc_in, stall_in, flush_in,
    output valid_out, alu_op, mux1_sel, mux2_sel, mux3_sel, jal_sel, imm_sel,
           regwrite_en, mem_read, mem_write, branch, jump, funct3_out,
           rd, rs1, rs2, pc_out, illegal_instr, stall_out
  );
endinterface

// File: rtl/decode_ctrl_pipe_decode_comb.sv
// Pure combinational RV32IM decoder: instruction word -> control bundle.
// Ports:
//   instr_i   instruction word
//   ctrl_o    control bundle (valid=1; illegal=1 with all enables 0 if undecodable)
//   is_mul_o  legal MUL/MULH/MULHSU/MULHU
//   is_div_o  legal DIV/DIVU/REM/REMU
module decode_comb
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        is_mul_o,
  output logic        is_div_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  always_comb begin
    ctrl_o          = '0;
    is_mul_o        = 1'b0;
    is_div_o        = 1'b0;
    legal           = 1'b1;
    ctrl_o.valid    = 1'b1;
    ctrl_o.funct3   = f3;
    ctrl_o.rd       = instr_i[11:7];
    ctrl_o.rs1      = instr_i[19:15];
    ctrl_o.rs2      = instr_i[24:20];

    case (opcode)
      OPC_LUI: begin
        ctrl_o.alu_op      = ALU_PASSB;
        ctrl_o.imm_sel     = IMM_U;
        ctrl_o.regwrite_en = 1'b1;
      end
      OPC_AUIPC: begin
        // mux2_sel=0 selects PC as operand A
        ctrl_o.alu_op      = ALU_ADD;
        ctrl_o.imm_sel     = IMM_U;
        ctrl_o.regwrite_en = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.alu_op      = ALU_ADD;
        ctrl_o.imm_sel     = IMM_J;
        ctrl_o.regwrite_en = 1'b1;
        ctrl_o.jump        = 1'b1;
        ctrl_o.jal_sel     = 1'b1;
      end
      OPC_JALR: begin
        legal              = (f3 == 3'b000);
        ctrl_o.alu_op      = ALU_ADD;
        ctrl_o.mux2_sel    = 1'b1;
        ctrl_o.imm_sel     = IMM_I;
        ctrl_o.regwrite_en = 1'b1;
        ctrl_o.jump        = 1'b1;
        ctrl_o.jal_sel     = 1'b1;
      end
      OPC_BRANCH: begin
        legal           = (f3 != 3'b010) && (f3 != 3'b011);
        ctrl_o.alu_op   = ALU_SUB;
        ctrl_o.mux1_sel = 1'b1;
        ctrl_o.mux2_sel = 1'b1;
        ctrl_o.imm_sel  = IMM_B;
        ctrl_o.branch   = 1'b1;
      end
      OPC_LOAD: begin
        legal              = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        ctrl_o.alu_op      = ALU_ADD;
        ctrl_o.mux2_sel    = 1'b1;
        ctrl_o.mux3_sel    = 1'b1;
        ctrl_o.imm_sel     = IMM_I;
        ctrl_o.regwrite_en = 1'b1;
        ctrl_o.mem_read    = 1'b1;
      end
      OPC_STORE: begin
        legal            = (f3[2] == 1'b0) && (f3 != 3'b011);
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.mux2_sel  = 1'b1;
        ctrl_o.imm_sel   = IMM_S;
        ctrl_o.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_o.mux2_sel    = 1'b1;
        ctrl_o.imm_sel     = IMM_I;
        ctrl_o.regwrite_en = 1'b1;
        case (f3)
          F3_ADD:  ctrl_o.alu_op = ALU_ADD;
          F3_SLT:  ctrl_o.alu_op = ALU_SLT;
          F3_SLTU: ctrl_o.alu_op = ALU_SLTU;
          F3_XOR:  ctrl_o.alu_op = ALU_XOR;
          F3_OR:   ctrl_o.alu_op = ALU_OR;
          F3_AND:  ctrl_o.alu_op = ALU_AND;
          F3_SLL: begin
            legal         = (f7 == F7_BASE);
            ctrl_o.alu_op = ALU_SLL;
          end
          default: begin
            // F3_SR: funct7 picks logical vs arithmetic shift
            legal         = (f7 == F7_BASE) || (f7 == F7_ALT);
            ctrl_o.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
        endcase
      end
      OPC_OP: begin
        ctrl_o.mux1_sel    = 1'b1;
        ctrl_o.mux2_sel    = 1'b1;
        ctrl_o.regwrite_en = 1'b1;
        if (f7 == F7_MULDIV) begin
          is_mul_o = ~f3[2];
          is_div_o = f3[2];
          case (f3)
            F3_MUL:    ctrl_o.alu_op = ALU_MUL;
            F3_MULH:   ctrl_o.alu_op = ALU_MULH;
            F3_MULHSU: ctrl_o.alu_op = ALU_MULHSU;
            F3_MULHU:  ctrl_o.alu_op = ALU_MULHU;
            F3_DIV:    ctrl_o.alu_op = ALU_DIV;
            F3_DIVU:   ctrl_o.alu_op = ALU_DIVU;
            F3_REM:    ctrl_o.alu_op = ALU_REM;
            default:   ctrl_o.alu_op = ALU_REMU;
          endcase
        end else if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  ctrl_o.alu_op = ALU_ADD;
            F3_SLL:  ctrl_o.alu_op = ALU_SLL;
            F3_SLT:  ctrl_o.alu_op = ALU_SLT;
            F3_SLTU: ctrl_o.alu_op = ALU_SLTU;
            F3_XOR:  ctrl_o.alu_op = ALU_XOR;
            F3_SR:   ctrl_o.alu_op = ALU_SRL;
            F3_OR:   ctrl_o.alu_op = ALU_OR;
            default: ctrl_o.alu_op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          legal         = (f3 == F3_ADD) || (f3 == F3_SR);
          ctrl_o.alu_op = (f3 == F3_SR) ? ALU_SRA : ALU_SUB;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase

    // Undecodable: keep the slot occupied but make it side-effect free
    if (!legal) begin
      ctrl_o         = '0;
      ctrl_o.valid   = 1'b1;
      ctrl_o.illegal = 1'b1;
      is_mul_o       = 1'b0;
      is_div_o       = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// RV32IM decode stage with registered ID/EX output, stall/flush handling and
// a hold FSM that keeps multi-cycle MUL/DIV ops in EX for their full latency.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      decode_ctrl_pipe_if.slave: instruction/PC/stall/flush in,
//            ID/EX control bundle, pc_out, illegal_instr and stall_out out
//
// state       | meaning
// ST_RUN      | normal flow, a new instruction loads every unstalled edge
// ST_MDU_WAIT | M op held in EX; cnt_q counts remaining unstalled cycles,
//             | stall_out high while cnt_q != 0
module decode_ctrl_pipe
  import rv32_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 8
) (
  input  logic clk,
  input  logic reset_n,
  decode_ctrl_pipe_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic MUL_HOLD = (MUL_LAT > 1);
  localparam logic DIV_HOLD = (DIV_LAT > 1);

  ctrl_t            dec_ctrl;
  logic             dec_is_mul;
  logic             dec_is_div;

  ctrl_t            ctrl_q;
  logic [XLEN-1:0]  pc_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_t            ctrl_d;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_d;

  decode_comb u_decode (
    .instr_i  (bus.instr_in),
    .ctrl_o   (dec_ctrl),
    .is_mul_o (dec_is_mul),
    .is_div_o (dec_is_div)
  );

  // What a load edge would capture
  always_comb begin
    ctrl_d  = '0;
    state_d = ST_RUN;
    cnt_d   = '0;
    if (bus.instr_valid) begin
      ctrl_d = dec_ctrl;
      if (dec_is_div && DIV_HOLD) begin
        state_d = ST_MDU_WAIT;
        cnt_d   = DIV_CNT;
      end else if (dec_is_mul && MUL_HOLD) begin
        state_d = ST_MDU_WAIT;
        cnt_d   = MUL_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      pc_q    <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (bus.flush_in) begin
      ctrl_q  <= '0;
      pc_q    <= '0;
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (bus.stall_in) begin
      ctrl_q  <= ctrl_q;
    end else if (state_q == ST_MDU_WAIT && cnt_q != '0) begin
      cnt_q   <= cnt_q - 1'b1;
    end else begin
      // RUN, or the last cycle of an MDU wait: load the next instruction
      ctrl_q  <= ctrl_d;
      pc_q    <= bus.instr_valid ? bus.pc_in : '0;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_out     = (state_q == ST_MDU_WAIT) && (cnt_q != '0);

  assign bus.valid_out     = ctrl_q.valid;
  assign bus.alu_op        = ALUOP_W'(ctrl_q.alu_op);
  assign bus.mux1_sel      = ctrl_q.mux1_sel;
  assign bus.mux2_sel      = ctrl_q.mux2_sel;
  assign bus.mux3_sel      = ctrl_q.mux3_sel;
  assign bus.jal_sel       = ctrl_q.jal_sel;
  assign bus.imm_sel       = ctrl_q.imm_sel;
  assign bus.regwrite_en   = ctrl_q.regwrite_en;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.branch        = ctrl_q.branch;
  assign bus.jump          = ctrl_q.jump;
  assign bus.funct3_out    = ctrl_q.funct3;
  assign bus.rd            = ctrl_q.rd;
  assign bus.rs1           = ctrl_q.rs1;
  assign bus.rs2           = ctrl_q.rs2;
  assign bus.pc_out        = pc_q;
  assign bus.illegal_instr = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  typedef struct packed {
    logic        valid;
    logic [4:0]  alu;
    logic        m1, m2, m3, jal;
    logic [2:0]  imm;
    logic        rw, mr, mw, br, jp;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        ill;
    logic [31:0] pc;
    logic        stall;
  } exp_t;

  localparam logic [31:0] ADD_I = 32'h002081B3;
  localparam logic [31:0] LW_I  = 32'h00412083;
  localparam logic [31:0] SW_I  = 32'h00112223;
  localparam logic [31:0] BEQ_I = 32'h00208463;
  localparam logic [31:0] MUL_I = 32'h027302B3;
  localparam logic [31:0] DIV_I = 32'h027342B3;
  localparam logic [31:0] BADOP = 32'h0000007F;
  localparam logic [31:0] BADF7 = 32'h042081B3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.XLEN(32), .ALUOP_W(5)) bus ();

  decode_ctrl_pipe #(.XLEN(32), .ALUOP_W(5), .MUL_LAT(1), .DIV_LAT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [4:0] alu, input logic m1, input logic m2,
                              input logic m3, input logic jal, input logic [2:0] imm,
                              input logic rw, input logic mr, input logic mw,
                              input logic br, input logic jp, input logic [31:0] ins,
                              input logic [31:0] pc, input logic stall);
    exp_t e = '0;
    e.valid = 1'b1;
    e.alu = alu; e.m1 = m1; e.m2 = m2; e.m3 = m3; e.jal = jal; e.imm = imm;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.jp = jp;
    e.f3 = ins[14:12]; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.pc = pc; e.stall = stall;
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e = '0;
    return e;
  endfunction

  function automatic exp_t ill(input logic [31:0] pc);
    exp_t e = '0;
    e.valid = 1'b1; e.ill = 1'b1; e.pc = pc;
    return e;
  endfunction

  function automatic exp_t e_add(input logic [31:0] pc);
    return mk(5'b00000, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 0, ADD_I, pc, 0);
  endfunction

  function automatic exp_t e_div(input logic [31:0] pc, input logic s);
    return mk(5'b01000, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 0, DIV_I, pc, s);
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.valid = bus.valid_out;   o.alu = bus.alu_op;
    o.m1 = bus.mux1_sel;       o.m2 = bus.mux2_sel;
    o.m3 = bus.mux3_sel;       o.jal = bus.jal_sel;
    o.imm = bus.imm_sel;       o.rw = bus.regwrite_en;
    o.mr = bus.mem_read;       o.mw = bus.mem_write;
    o.br = bus.branch;         o.jp = bus.jump;
    o.f3 = bus.funct3_out;     o.rd = bus.rd;
    o.rs1 = bus.rs1;           o.rs2 = bus.rs2;
    o.ill = bus.illegal_instr; o.pc = bus.pc_out;
    o.stall = bus.stall_out;
    return o;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    exp_t o;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, nothing to compare", tag);
    end else begin
      e = sb_q.pop_front();
      o = observed();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", tag, o, e);
      end
    end
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic v,
                      input logic [31:0] pc, input logic st, input logic fl,
                      input exp_t e);
    bus.instr_in    = instr;
    bus.instr_valid = v;
    bus.pc_in       = pc;
    bus.stall_in    = st;
    bus.flush_in    = fl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.instr_in    = '0;
    bus.instr_valid = 1'b0;
    bus.pc_in       = '0;
    bus.stall_in    = 1'b0;
    bus.flush_in    = 1'b0;
    #12;
    sb_q.push_back(bub());
    check("reset");
    @(negedge clk);
    reset_n = 1'b1;

    step("add", ADD_I, 1, 32'h100, 0, 0, e_add(32'h100));
    step("stall_run", LW_I, 1, 32'h104, 1, 0, e_add(32'h100));
    step("lw", LW_I, 1, 32'h104, 0, 0,
         mk(5'b00000, 0, 1, 1, 0, 3'b000, 1, 1, 0, 0, 0, LW_I, 32'h104, 0));
    step("sw", SW_I, 1, 32'h108, 0, 0,
         mk(5'b00000, 0, 1, 0, 0, 3'b001, 0, 0, 1, 0, 0, SW_I, 32'h108, 0));
    step("beq", BEQ_I, 1, 32'h10C, 0, 0,
         mk(5'b10000, 1, 1, 0, 0, 3'b010, 0, 0, 0, 1, 0, BEQ_I, 32'h10C, 0));
    step("mul", MUL_I, 1, 32'h110, 0, 0,
         mk(5'b00100, 1, 1, 0, 0, 3'b000, 1, 0, 0, 0, 0, MUL_I, 32'h110, 0));
    step("after_mul", ADD_I, 1, 32'h114, 0, 0, e_add(32'h114));

    // DIV: 8 cycles in EX, stall_out for the first 7, back-to-back DIV next
    step("div_load", DIV_I, 1, 32'h200, 0, 0, e_div(32'h200, 1));
    for (int i = 0; i < 6; i++)
      step("div_wait", DIV_I, 1, 32'h204, 0, 0, e_div(32'h200, 1));
    step("div_last", DIV_I, 1, 32'h204, 0, 0, e_div(32'h200, 0));
    step("div2_load", DIV_I, 1, 32'h204, 0, 0, e_div(32'h204, 1));
    for (int i = 0; i < 2; i++)
      step("div2_wait", ADD_I, 1, 32'h208, 0, 0, e_div(32'h204, 1));
    for (int i = 0; i < 2; i++)
      step("div2_stall", ADD_I, 1, 32'h208, 1, 0, e_div(32'h204, 1));
    for (int i = 0; i < 4; i++)
      step("div2_wait2", ADD_I, 1, 32'h208, 0, 0, e_div(32'h204, 1));
    step("div2_last", ADD_I, 1, 32'h208, 0, 0, e_div(32'h204, 0));
    step("after_div2", ADD_I, 1, 32'h208, 0, 0, e_add(32'h208));

    // Flush during a DIV wait
    step("div3_load", DIV_I, 1, 32'h300, 0, 0, e_div(32'h300, 1));
    step("div3_wait", ADD_I, 1, 32'h304, 0, 0, e_div(32'h300, 1));
    step("div3_flush", ADD_I, 1, 32'h304, 0, 1, bub());
    step("after_flush", ADD_I, 1, 32'h304, 0, 0, e_add(32'h304));
    step("flush_stall", ADD_I, 1, 32'h308, 1, 1, bub());

    // Illegal and invalid
    step("ill_opcode", BADOP, 1, 32'h400, 0, 0, ill(32'h400));
    step("ill_funct7", BADF7, 1, 32'h404, 0, 0, ill(32'h404));
    step("not_valid", ADD_I, 0, 32'h408, 0, 0, bub());

    // Asynchronous reset in the middle of a DIV wait
    step("div4_load", DIV_I, 1, 32'h500, 0, 0, e_div(32'h500, 1));
    step("div4_wait", ADD_I, 1, 32'h504, 0, 0, e_div(32'h500, 1));
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.push_back(bub());
    check("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset", ADD_I, 1, 32'h504, 0, 0, e_add(32'h504));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
